// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the result-writeback arbiter.
// Producer indices, ROB tag range and the {tag, value} result bundle.
package cdb_arbiter_pkg;

  localparam int TAG_W   = 3;
  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 3;
  localparam int SRC_W   = 2;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;
  localparam logic [TAG_W-1:0] ROB_MIN  = 3'd1;
  localparam logic [TAG_W-1:0] ROB_MAX  = 3'd7;

  localparam logic [SRC_W-1:0] SRC_ALU = 2'd0;
  localparam logic [SRC_W-1:0] SRC_LSU = 2'd1;
  localparam logic [SRC_W-1:0] SRC_BR  = 2'd2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } result_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer push handshakes plus the registered common-data-bus.
// slave = arbiter side, master = producers and bus snoopers.
interface cdb_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_value;
  logic [N_REQ-1:0]        req_ready;
  logic [TAG_W-1:0]        cdb_num;
  logic [DATA_W-1:0]       cdb_value;
  logic [1:0]              cdb_src;
  logic                    conflict;

  modport master (
    output req_valid,
    output req_tag,
    output req_value,
    input  req_ready,
    input  cdb_num,
    input  cdb_value,
    input  cdb_src,
    input  conflict
  );

  modport slave (
    input  req_valid,
    input  req_tag,
    input  req_value,
    output req_ready,
    output cdb_num,
    output cdb_value,
    output cdb_src,
    output conflict
  );

endinterface

// File: rtl/cdb_arbiter_queue.sv
// Per-producer result FIFO: DEPTH entries, push/pop/clear.
// Caller guarantees no push when full and no pop when empty.
module cdb_queue #(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [TAG_W-1:0]           push_tag,
  input  logic [DATA_W-1:0]          push_value,
  output logic [TAG_W-1:0]           head_tag,
  output logic [DATA_W-1:0]          head_value,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q].tag   = push_tag;
        mem_d[wr_q].value = push_value;
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      // push+pop together leaves count alone
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign head_tag   = mem_q[rd_q].tag;
  assign head_value = mem_q[rd_q].value;
  assign count      = cnt_q;
  assign full       = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin writeback arbiter: N_REQ producer queues onto one
// registered common-data-bus snooped by ROB, RS and LSB.
module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  import cdb_arbiter_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [N_REQ-1:0]  push;
  logic [N_REQ-1:0]  pop;
  logic [N_REQ-1:0]  full;
  logic [N_REQ-1:0]  elig;
  logic [CW-1:0]     cnt      [N_REQ];
  logic [TAG_W-1:0]  head_tag [N_REQ];
  logic [DATA_W-1:0] head_val [N_REQ];

  logic              found;
  logic [SRC_W-1:0]  win;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_val;

  logic [TAG_W-1:0]  num_q, num_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [SRC_W-1:0]  last_q, last_d;
  logic              conf_q, conf_d;

  // First eligible queue after `last`, wrapping; {hit, index}.
  function automatic logic [SRC_W:0] rr_pick(
    input logic [N_REQ-1:0] el,
    input logic [SRC_W-1:0] last
  );
    logic             hit;
    logic [SRC_W-1:0] sel;
    hit = 1'b0;
    sel = last;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!hit && el[j] && (j == (int'(last) + k) % N_REQ)) begin
          hit = 1'b1;
          sel = SRC_W'(j);
        end
      end
    end
    return {hit, sel};
  endfunction

  assign {found, win} = rr_pick(elig, last_q);

  for (genvar g = 0; g < N_REQ; g++) begin : g_q
    logic [TAG_W-1:0]  in_tag;
    logic [DATA_W-1:0] in_val;

    assign in_tag = bus.req_tag[g*TAG_W +: TAG_W];
    assign in_val = bus.req_value[g*DATA_W +: DATA_W];

    assign bus.req_ready[g] = !full[g] && !rst;
    assign elig[g] = (cnt[g] != '0);

    // tag 0 handshakes but never enqueues
    assign push[g] = bus.req_valid[g] && bus.req_ready[g]
                  && (in_tag != '0) && !flush;
    assign pop[g]  = found && (win == SRC_W'(g)) && !flush;

    cdb_queue #(
      .DEPTH  (DEPTH),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_q (
      .clk        (clk),
      .rst        (rst),
      .clear      (flush),
      .push       (push[g]),
      .pop        (pop[g]),
      .push_tag   (in_tag),
      .push_value (in_val),
      .head_tag   (head_tag[g]),
      .head_value (head_val[g]),
      .count      (cnt[g]),
      .full       (full[g])
    );
  end

  always_comb begin
    sel_tag = '0;
    sel_val = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == SRC_W'(i)) begin
        sel_tag = head_tag[i];
        sel_val = head_val[i];
      end
    end
  end

  always_comb begin
    num_d  = '0;
    val_d  = val_q;
    src_d  = src_q;
    last_d = last_q;
    conf_d = 1'b0;
    if (flush) begin
      last_d = SRC_W'(N_REQ - 1);
    end else if (found) begin
      num_d  = sel_tag;
      val_d  = sel_val;
      src_d  = win;
      last_d = win;
      conf_d = ($countones(elig) >= 2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q  <= '0;
      val_q  <= '0;
      src_q  <= '0;
      conf_q <= 1'b0;
      last_q <= SRC_W'(N_REQ - 1);
    end else begin
      num_q  <= num_d;
      val_q  <= val_d;
      src_q  <= src_d;
      conf_q <= conf_d;
      last_q <= last_d;
    end
  end

  assign bus.cdb_num   = num_q;
  assign bus.cdb_value = val_q;
  assign bus.cdb_src   = src_q;
  assign bus.conflict  = conf_q;

endmodule
